flash_cmd_engine: RTL and testbench

Parametrised command engine for Intel-style (CFI command set) parallel NOR flash. It sits between the bus-side memory controller and the board flash pins. It accepts one request at a time (read, program, block erase, read status) over a valid/ready handshake and generates the WE/OE/CE pin sequences with programmable pulse and wait widths. Beyond a basic driver, it tracks read-array mode to skip redundant 0xFF commands, decodes status-register errors with automatic clear-status, and bounds status polling with a timeout.

---
 rtl/flash_cmd_engine.sv | 243 ++++++++++++++++++++++++
 tb/tb_flash_cmd_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_cmd_engine.sv
// rtl/flash_cmd_engine.sv - CFI (Intel-style) parallel NOR flash command engine
// Pins are registered from the next state so strobes never glitch between phases.
module flash_cmd_engine #(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 16,
  parameter int WE_PULSE  = 1,
  parameter int READ_WAIT = 4,
  parameter int TIMEOUT_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_err,
  output logic [ADDR_W:0]   flash_addr,
  output logic [DATA_W-1:0] flash_dq_o,
  output logic              flash_dq_oe,
  input  logic [DATA_W-1:0] flash_dq_i,
  output logic              flash_ce_n,
  output logic              flash_we_n,
  output logic              flash_oe_n,
  output logic              flash_byte_n,
  output logic              flash_rp_n,
  output logic              flash_vpen
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_C1_WE    = 4'd1;
  localparam logic [3:0] S_C1_HOLD  = 4'd2;
  localparam logic [3:0] S_C2_WE    = 4'd3;
  localparam logic [3:0] S_C2_HOLD  = 4'd4;
  localparam logic [3:0] S_RD_OE    = 4'd5;
  localparam logic [3:0] S_SR_WE    = 4'd6;
  localparam logic [3:0] S_SR_HOLD  = 4'd7;
  localparam logic [3:0] S_SR_OE    = 4'd8;
  localparam logic [3:0] S_SR_GAP   = 4'd9;
  localparam logic [3:0] S_CLR_WE   = 4'd10;
  localparam logic [3:0] S_CLR_HOLD = 4'd11;
  localparam logic [3:0] S_RESP     = 4'd12;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_PROG  = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b10;
  localparam logic [1:0] OP_STAT  = 2'b11;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_PE  = 2'b01;
  localparam logic [1:0] ERR_VPP = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  localparam int CNT_MAX = (WE_PULSE > READ_WAIT) ? WE_PULSE : READ_WAIT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [3:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [7:0]           status_q, status_d;
  logic [DATA_W-1:0]    pend_data_q, pend_data_d;
  logic [1:0]           pend_err_q, pend_err_d;
  logic                 array_mode_q, array_d;
  logic [1:0]           op_q, op_n;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W-1:0]    dq_d;
  logic                 accept, last_we, last_rd, timed_out;
  logic                 we_low_d, oe_low_d, drive_d, ce_low_d;

  function automatic logic [DATA_W-1:0] cmd1_for(input logic [1:0] op);
    case (op)
      OP_READ:  cmd1_for = DATA_W'(8'hFF);
      OP_PROG:  cmd1_for = DATA_W'(8'h40);
      OP_ERASE: cmd1_for = DATA_W'(8'h20);
      default:  cmd1_for = DATA_W'(8'h70);
    endcase
  endfunction

  assign req_ready    = (state_q == S_IDLE);
  assign accept       = req_valid && req_ready;
  assign op_n         = accept ? req_op : op_q;
  assign last_we      = (cnt_q == CNT_W'(WE_PULSE - 1));
  assign last_rd      = (cnt_q == CNT_W'(READ_WAIT - 1));
  assign timed_out    = (op_q != OP_STAT) && (tmo_q == '1);
  assign flash_addr   = {addr_q, 1'b0};
  assign flash_byte_n = 1'b1;
  assign flash_rp_n   = 1'b1;
  assign flash_vpen   = 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_W'(1);
    tmo_d       = tmo_q;
    status_d    = status_q;
    pend_data_d = pend_data_q;
    pend_err_d  = pend_err_q;
    array_d     = array_mode_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_op == OP_READ) begin
            state_d = array_mode_q ? S_RD_OE : S_C1_WE;
          end else begin
            array_d = 1'b0;
            state_d = (req_op == OP_STAT) ? S_SR_WE : S_C1_WE;
          end
        end
      end
      S_C1_WE:   if (last_we) state_d = S_C1_HOLD;
      S_C1_HOLD: state_d = (op_q == OP_READ) ? S_RD_OE : S_C2_WE;
      S_C2_WE:   if (last_we) state_d = S_C2_HOLD;
      S_C2_HOLD: state_d = S_SR_WE;
      S_RD_OE: begin
        if (last_rd) begin
          pend_data_d = flash_dq_i;
          pend_err_d  = ERR_OK;
          array_d     = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_SR_WE: begin
        tmo_d = '0;
        if (last_we) state_d = S_SR_HOLD;
      end
      S_SR_HOLD: state_d = S_SR_OE;
      S_SR_OE: begin
        tmo_d = tmo_q + TIMEOUT_W'(1);
        if (timed_out) begin
          pend_data_d = {{(DATA_W-8){1'b0}}, status_q};
          pend_err_d  = ERR_TMO;
          state_d     = S_RESP;
        end else if (last_rd) begin
          // Error bits are only meaningful once SR7 reports ready; SR3 outranks SR5/SR4.
          status_d    = flash_dq_i[7:0];
          pend_data_d = {{(DATA_W-8){1'b0}}, flash_dq_i[7:0]};
          pend_err_d  = ERR_OK;
          if (op_q == OP_STAT) begin
            state_d = S_RESP;
          end else if (!flash_dq_i[7]) begin
            state_d = S_SR_GAP;
          end else if (flash_dq_i[3]) begin
            pend_err_d = ERR_VPP;
            state_d    = S_CLR_WE;
          end else if (flash_dq_i[5] || flash_dq_i[4]) begin
            pend_err_d = ERR_PE;
            state_d    = S_CLR_WE;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_SR_GAP: begin
        tmo_d = tmo_q + TIMEOUT_W'(1);
        if (timed_out) begin
          pend_data_d = {{(DATA_W-8){1'b0}}, status_q};
          pend_err_d  = ERR_TMO;
          state_d     = S_RESP;
        end else begin
          state_d = S_SR_OE;
        end
      end
      S_CLR_WE:   if (last_we) state_d = S_CLR_HOLD;
      S_CLR_HOLD: state_d = S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    dq_d     = flash_dq_o;
    we_low_d = 1'b0;
    oe_low_d = 1'b0;
    drive_d  = 1'b0;
    case (state_d)
      S_C1_WE, S_C1_HOLD:   dq_d = cmd1_for(op_n);
      S_C2_WE, S_C2_HOLD:   dq_d = (op_q == OP_PROG) ? wdata_q : DATA_W'(8'hD0);
      S_SR_WE, S_SR_HOLD:   dq_d = DATA_W'(8'h70);
      S_CLR_WE, S_CLR_HOLD: dq_d = DATA_W'(8'h50);
      default:              dq_d = flash_dq_o;
    endcase
    case (state_d)
      S_C1_WE, S_C2_WE, S_SR_WE, S_CLR_WE: begin
        we_low_d = 1'b1;
        drive_d  = 1'b1;
      end
      S_C1_HOLD, S_C2_HOLD, S_SR_HOLD, S_CLR_HOLD: drive_d = 1'b1;
      S_RD_OE, S_SR_OE: oe_low_d = 1'b1;
      default: drive_d = 1'b0;
    endcase
    ce_low_d = (state_d != S_IDLE) && (state_d != S_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      status_q     <= '0;
      pend_data_q  <= '0;
      pend_err_q   <= ERR_OK;
      array_mode_q <= 1'b0;
      op_q         <= OP_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= ERR_OK;
      flash_dq_o   <= '0;
      flash_dq_oe  <= 1'b0;
      flash_ce_n   <= 1'b1;
      flash_we_n   <= 1'b1;
      flash_oe_n   <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      status_q     <= status_d;
      pend_data_q  <= pend_data_d;
      pend_err_q   <= pend_err_d;
      array_mode_q <= array_d;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      resp_valid <= (state_d == S_RESP);
      if (state_d == S_RESP) begin
        resp_rdata <= pend_data_d;
        resp_err   <= pend_err_d;
      end
      flash_dq_o  <= dq_d;
      flash_dq_oe <= drive_d;
      flash_ce_n  <= !ce_low_d;
      flash_we_n  <= !we_low_d;
      flash_oe_n  <= !oe_low_d;
    end
  end

endmodule

// File: tb/tb_flash_cmd_engine.sv
// tb/tb_flash_cmd_engine.sv - self-checking bench for flash_cmd_engine
// Vector table + scoreboard on a default instance; a second instance with a short timeout.
module tb_flash_cmd_engine;
  localparam int AW = 22;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic          req_valid, req_ready, resp_valid, flash_dq_oe;
  logic [1:0]    req_op, resp_err;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, resp_rdata, flash_dq_o, flash_dq_i;
  logic [AW:0]   flash_addr;
  logic          flash_ce_n, flash_we_n, flash_oe_n, flash_byte_n, flash_rp_n, flash_vpen;

  flash_cmd_engine #(.ADDR_W(AW), .DATA_W(DW), .WE_PULSE(1), .READ_WAIT(4), .TIMEOUT_W(20)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .flash_addr(flash_addr), .flash_dq_o(flash_dq_o), .flash_dq_oe(flash_dq_oe),
    .flash_dq_i(flash_dq_i), .flash_ce_n(flash_ce_n), .flash_we_n(flash_we_n), .flash_oe_n(flash_oe_n),
    .flash_byte_n(flash_byte_n), .flash_rp_n(flash_rp_n), .flash_vpen(flash_vpen)
  );

  logic          t_req_valid, t_req_ready, t_resp_valid, t_dq_oe;
  logic [1:0]    t_req_op, t_resp_err;
  logic [AW-1:0] t_req_addr;
  logic [DW-1:0] t_req_wdata, t_resp_rdata, t_dq_o;
  logic [DW-1:0] t_dq_i;
  logic [AW:0]   t_addr;
  logic          t_ce_n, t_we_n, t_oe_n, t_byte_n, t_rp_n, t_vpen;
  assign t_dq_i = 16'h0000;

  flash_cmd_engine #(.ADDR_W(AW), .DATA_W(DW), .WE_PULSE(1), .READ_WAIT(4), .TIMEOUT_W(4)) dut_t (
    .clk(clk), .rst(rst), .req_valid(t_req_valid), .req_ready(t_req_ready), .req_op(t_req_op),
    .req_addr(t_req_addr), .req_wdata(t_req_wdata), .resp_valid(t_resp_valid), .resp_rdata(t_resp_rdata),
    .resp_err(t_resp_err), .flash_addr(t_addr), .flash_dq_o(t_dq_o), .flash_dq_oe(t_dq_oe),
    .flash_dq_i(t_dq_i), .flash_ce_n(t_ce_n), .flash_we_n(t_we_n), .flash_oe_n(t_oe_n),
    .flash_byte_n(t_byte_n), .flash_rp_n(t_rp_n), .flash_vpen(t_vpen)
  );

  // Flash chip model: command decoder, status register with a busy-poll count.
  logic [15:0] model_array = 16'h0000;
  logic [7:0]  model_sr = 8'h00;
  int          model_busy = 0;
  logic        status_mode = 1'b0, await_prog = 1'b0, await_conf = 1'b0;
  int          busy_left = 0;
  logic        prev_we = 1'b1, prev_oe = 1'b1, t_prev_we = 1'b1;
  logic [15:0] obs_cmd[$];
  logic [AW:0] obs_addr[$];
  logic [15:0] t_cmds[$];

  assign flash_dq_i = status_mode ? ((busy_left > 0) ? 16'h0000 : {8'h00, model_sr}) : model_array;

  always @(negedge clk) begin
    if (!flash_we_n && prev_we) begin
      obs_cmd.push_back(flash_dq_o);
      obs_addr.push_back(flash_addr);
      if (await_prog) begin
        await_prog = 1'b0; status_mode = 1'b1; busy_left = model_busy;
      end else if (await_conf && flash_dq_o[7:0] == 8'hD0) begin
        await_conf = 1'b0; status_mode = 1'b1; busy_left = model_busy;
      end else begin
        case (flash_dq_o[7:0])
          8'hFF: status_mode = 1'b0;
          8'h70: status_mode = 1'b1;
          8'h40: await_prog = 1'b1;
          8'h20: await_conf = 1'b1;
          default: ;
        endcase
      end
    end
    if (flash_oe_n && !prev_oe && status_mode && busy_left > 0) busy_left--;
    prev_we = flash_we_n;
    prev_oe = flash_oe_n;
    if (!t_we_n && t_prev_we) t_cmds.push_back(t_dq_o);
    t_prev_we = t_we_n;
  end

  function automatic logic pins_ok(input logic ce_n, input logic we_n, input logic oe_n, input logic oe);
    return !((!oe_n && oe) || (!we_n && !oe_n) || ((!we_n || !oe_n) && ce_n));
  endfunction

  always @(negedge clk) begin
    check("pin_invariant", 32'(pins_ok(flash_ce_n, flash_we_n, flash_oe_n, flash_dq_oe)), 32'd1);
    check("pin_invariant_t", 32'(pins_ok(t_ce_n, t_we_n, t_oe_n, t_dq_oe)), 32'd1);
  end

  typedef struct {
    logic [15:0]      rdata;
    logic [1:0]       err;
    int               lat;
    logic [AW:0]      faddr;
    int               ncmd;
    logic [3:0][15:0] cmds;
    int               acc;
  } exp_t;

  typedef struct {
    logic [1:0]       op;
    logic [AW-1:0]    addr;
    logic [15:0]      wdata;
    logic [15:0]      arr;
    logic [7:0]       sr;
    int               busy;
    logic [15:0]      rdata;
    logic [1:0]       err;
    int               lat;
    int               ncmd;
    logic [3:0][15:0] cmds;
  } vec_t;

  exp_t sb[$];
  exp_t cur;
  int   resp_cnt = 0;
  vec_t vecs[13];

  always @(negedge clk) begin
    if (resp_valid) begin
      resp_cnt++;
      if (sb.size() == 0) begin
        check("resp_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        cur = sb.pop_front();
        check("rdata", 32'(resp_rdata), 32'(cur.rdata));
        check("err", 32'(resp_err), 32'(cur.err));
        check("latency", 32'(cyc - cur.acc), 32'(cur.lat));
        check("flash_addr", 32'(flash_addr), 32'(cur.faddr));
        check("cmd_count", 32'(obs_cmd.size()), 32'(cur.ncmd));
        for (int i = 0; i < cur.ncmd; i++)
          check("cmd_value", 32'((i < obs_cmd.size()) ? obs_cmd[i] : 16'hDEAD), 32'(cur.cmds[i]));
        foreach (obs_addr[i]) check("cmd_addr", 32'(obs_addr[i]), 32'(cur.faddr));
      end
    end
  end

  function automatic logic [3:0][15:0] c4(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  task automatic issue(input vec_t v);
    exp_t e;
    int   start;
    int   n;
    model_array = v.arr;
    model_sr    = v.sr;
    model_busy  = v.busy;
    @(negedge clk);
    obs_cmd.delete();
    obs_addr.delete();
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready", 32'(req_ready), 32'd1);
    e.rdata = v.rdata; e.err = v.err; e.lat = v.lat; e.faddr = {v.addr, 1'b0};
    e.ncmd = v.ncmd; e.cmds = v.cmds; e.acc = cyc;
    sb.push_back(e);
    start = resp_cnt;
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    while (resp_cnt == start && n < 200) begin @(negedge clk); n++; end
    check("resp_seen", 32'(resp_cnt - start), 32'd1);
  endtask

  initial begin
    int start;
    int n;
    int acc;
    int n50;
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int start;
    int n;
    int acc;
    int n50;
    req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_wdata = '0;
    t_req_valid = 1'b0; t_req_op = 2'd0; t_req_addr = '0; t_req_wdata = '0;
    //             op     addr          wdata     arr       sr    busy rdata     err  lat ncmd cmds
    vecs[0]  = '{2'd0, 22'h000010, 16'h0000, 16'hBEEF, 8'h00, 0, 16'hBEEF, 2'd0, 7, 1, c4(16'hFF, 0, 0, 0)};
    vecs[1]  = '{2'd0, 22'h000011, 16'h0000, 16'hC0DE, 8'h00, 0, 16'hC0DE, 2'd0, 5, 0, c4(0, 0, 0, 0)};
    vecs[2]  = '{2'd1, 22'h3FFFFF, 16'h1234, 16'h0000, 8'h80, 3, 16'h0080, 2'd0, 26, 3, c4(16'h40, 16'h1234, 16'h70, 0)};
    vecs[3]  = '{2'd0, 22'h000020, 16'h0000, 16'h5A5A, 8'h00, 0, 16'h5A5A, 2'd0, 7, 1, c4(16'hFF, 0, 0, 0)};
    vecs[4]  = '{2'd2, 22'h001000, 16'h0000, 16'h0000, 8'hA0, 0, 16'h00A0, 2'd1, 13, 4, c4(16'h20, 16'hD0, 16'h70, 16'h50)};
    vecs[5]  = '{2'd2, 22'h002000, 16'h0000, 16'h0000, 8'h88, 1, 16'h0088, 2'd2, 18, 4, c4(16'h20, 16'hD0, 16'h70, 16'h50)};
    vecs[6]  = '{2'd3, 22'h000005, 16'h0000, 16'h0000, 8'h80, 0, 16'h0080, 2'd0, 7, 1, c4(16'h70, 0, 0, 0)};
    vecs[7]  = '{2'd1, 22'h000100, 16'hFFFF, 16'h0000, 8'h90, 0, 16'h0090, 2'd1, 13, 4, c4(16'h40, 16'hFFFF, 16'h70, 16'h50)};
    vecs[8]  = '{2'd0, 22'h3FFFFF, 16'h0000, 16'h1111, 8'h00, 0, 16'h1111, 2'd0, 7, 1, c4(16'hFF, 0, 0, 0)};
    vecs[9]  = '{2'd1, 22'h000ABC, 16'hA5A5, 16'h0000, 8'hB8, 0, 16'h00B8, 2'd2, 13, 4, c4(16'h40, 16'hA5A5, 16'h70, 16'h50)};
    vecs[10] = '{2'd0, 22'h000040, 16'h0000, 16'h7777, 8'h00, 0, 16'h7777, 2'd0, 7, 1, c4(16'hFF, 0, 0, 0)};
    vecs[11] = '{2'd0, 22'h000044, 16'h0000, 16'h3C3C, 8'h00, 0, 16'h3C3C, 2'd0, 7, 1, c4(16'hFF, 0, 0, 0)};
    vecs[12] = '{2'd0, 22'h000045, 16'h0000, 16'h6B6B, 8'h00, 0, 16'h6B6B, 2'd0, 5, 0, c4(0, 0, 0, 0)};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_strobes", 32'({flash_ce_n, flash_we_n, flash_oe_n}), 32'd7);
    check("rst_dq_oe", 32'(flash_dq_oe), 32'd0);
    check("rst_dq_o", 32'(flash_dq_o), 32'd0);
    check("const_pins", 32'({flash_byte_n, flash_rp_n, flash_vpen}), 32'd7);

    for (int i = 0; i <= 10; i++) issue(vecs[i]);

    // Reset in the middle of an array-mode read (RD_OE entered straight from IDLE).
    @(negedge clk);
    obs_cmd.delete();
    obs_addr.delete();
    req_valid = 1'b1; req_op = 2'd0; req_addr = 22'h000044; req_wdata = '0;
    start = resp_cnt;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_rd_oe_low", 32'(flash_oe_n), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_strobes", 32'({flash_ce_n, flash_we_n, flash_oe_n}), 32'd7);
    check("mid_rst_dq_oe", 32'(flash_dq_oe), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("mid_rst_no_resp", 32'(resp_cnt - start), 32'd0);

    for (int i = 11; i < 13; i++) issue(vecs[i]);

    // Timeout instance: status stays busy forever.
    @(negedge clk);
    t_cmds.delete();
    t_req_valid = 1'b1; t_req_op = 2'd1; t_req_addr = 22'h000055; t_req_wdata = 16'h0F0F;
    check("t_req_ready", 32'(t_req_ready), 32'd1);
    acc = cyc;
    @(posedge clk); #1 t_req_valid = 1'b0;
    n = 0;
    while (!t_resp_valid && n < 100) begin @(negedge clk); n++; end
    check("t_resp_seen", 32'(t_resp_valid), 32'd1);
    check("t_err", 32'(t_resp_err), 32'd3);
    check("t_latency", 32'(cyc - acc), 32'd23);
    check("t_rdata", 32'(t_resp_rdata), 32'd0);
    check("t_cmd_count", 32'(t_cmds.size()), 32'd3);
    n50 = 0;
    foreach (t_cmds[i]) if (t_cmds[i] == 16'h0050) n50++;
    check("t_no_clear_status", 32'(n50), 32'd0);
    while (t_cmds.size() < 3) t_cmds.push_back(16'hDEAD);
    check("t_cmd0", 32'(t_cmds[0]), 32'h40);
    check("t_cmd1", 32'(t_cmds[1]), 32'h0F0F);
    check("t_cmd2", 32'(t_cmds[2]), 32'h70);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
